frame_serializer: RTL and testbench
===================================

# frame_serializer

Parallel-to-serial unloader for the modem datapath. It accepts a whole frame of `FIFO_SIZE` words in one parallel transfer, in the same packed layout the `fifo` sample window produces. It then emits the words one per beat on a valid/ready stream toward the BPSK transmit path. It is the reverse direction of the `fifo` shift window: that block packs a word stream into a parallel frame, and this block unpacks a parallel frame back into a word stream.

## Interface
- `FIFO_SIZE`, 4, words per frame; legal range ≥ 1.
- `DATA_WIDTH`, 8, bits per word; legal range ≥ 1.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `frame_in`  input  FIFO_SIZE*DATA_WIDTH  packed frame; word k = `frame_in[k*DATA_WIDTH +: DATA_WIDTH]`.
- `frame_valid`  input  1  `frame_in` is valid.
- `frame_ready`  output  1  serializer can capture a frame this cycle.
- `data_out`  output  DATA_WIDTH  current output word.
- `data_valid`  output  1  `data_out` is valid.
- `data_ready`  input  1  downstream accepts `data_out` this cycle.
- `data_last`  output  1  `data_out` is word FIFO_SIZE-1 of the frame.
- `busy`  output  1  a frame is held; equals `data_valid`.

## Operation
- **Internal state:**
  - frame register, FIFO_SIZE*DATA_WIDTH bits.
  - word index `idx`, width max(1, $clog2(FIFO_SIZE)).
  - state IDLE/SHIFT.
- **Transfer definitions:**
  - Frame accept: `frame_valid && frame_ready` at a rising edge.
  - Beat: `data_valid && data_ready` at a rising edge.
- **IDLE:**
  - `data_valid=0`, `frame_ready=1`.
  - On frame accept: capture `frame_in`, set `idx=0`, go to SHIFT.
- **SHIFT:**
  - `data_valid=1`, `data_out` = word `idx` of the captured frame, `data_last = (idx == FIFO_SIZE-1)`.
  - Beat with `!data_last`: `idx` increments.
  - Beat with `data_last` and no frame accept: go to IDLE.
  - Beat with `data_last` and a frame accept in the same cycle: capture the new frame, set `idx=0`, stay in SHIFT. There is no bubble between frames.
- **`frame_ready`:** `!data_valid || (data_last && data_ready)`. This is a combinational path from `data_ready` to `frame_ready`, and it is intentional.
- **Word order:** word 0 (lowest bits) is emitted first and word FIFO_SIZE-1 last.
- **Ignored inputs:**
  - `frame_in` and `frame_valid` while `frame_ready=0`.
  - `data_ready` while `data_valid=0`.
- **FIFO_SIZE=1:** every output word has `data_last=1`, and back-to-back frames sustain one word per cycle.
- **Data handling:** words pass through unmodified, with no arithmetic on data. `idx` never exceeds FIFO_SIZE-1 and resets to 0 on each capture (no free-running wrap).

## Timing
- **Reset values (while `rst_n=0`, immediately on assertion):**
  - state=IDLE, `idx=0`, frame register=0.
  - `data_valid=0`, `data_last=0`, `busy=0`, `data_out=0`.
  - `frame_ready=1`.
- **Reset mid-frame:** the remaining words are discarded. After release the block is in IDLE.
- **Latency:** a frame accepted at edge N gives `data_valid=1` with word 0 during cycle N+1.
- **Throughput:** with `data_ready` held high, a frame occupies exactly FIFO_SIZE cycles and back-to-back frames are gapless.
- **Stall:** while `data_ready=0` and `data_valid=1`, `data_out`, `data_last` and `idx` hold stable.
- **Stream rule:** `data_valid` never deasserts without a beat.
- **Output timing:** `data_out`, `data_valid` and `data_last` are register- or mux-driven from state only, with no combinational path from inputs.

## Test plan
- **Reset:** assert `rst_n=0` mid-SHIFT, then release.
  - During reset: `data_valid=0`, `data_out=0`, `frame_ready=1`.
  - After release: a new frame 0x44332211 emits 0x11 first.
- **Single frame, free-flowing** (FIFO_SIZE=4, DATA_WIDTH=8): load 0x04030201 with `data_ready=1`.
  - Outputs 0x01, 0x02, 0x03, 0x04 on 4 consecutive cycles starting 1 cycle after accept.
  - `data_last` high only with 0x04.
- **Backpressure:** same frame, `data_ready` pattern 1,0,0,1,1,0,1.
  - Each word is held while stalled and no word is skipped or duplicated.
  - `frame_ready=0` until the last beat.
- **Back-to-back frames:** present 0x04030201 then 0x08070605 with `frame_valid` held high.
  - The second frame is accepted on the 0x04 beat.
  - Output is 0x01…0x08 on 8 consecutive cycles with no gap.
- **Ignored load:** pulse `frame_valid` with 0xDEADBEEF mid-frame.
  - It is not captured and the current frame completes unchanged.
- **FIFO_SIZE=1:** stream bytes 0x01,0x02,0x03 as consecutive frames.
  - One output per cycle, `data_last=1` on each.

Source files
------------

// File: rtl/frame_serializer.sv
// Parallel-to-serial unloader: captures a packed frame of FIFO_SIZE words and
// emits them word 0 first on a valid/ready stream, with no bubble between frames.
module frame_serializer #(
    parameter int FIFO_SIZE  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [FIFO_SIZE*DATA_WIDTH-1:0] frame_in,
    input  logic                            frame_valid,
    output logic                            frame_ready,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic                            data_last,
    output logic                            busy
);

    localparam int IDX_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIFO_SIZE - 1);

    // Handshake: a transfer happens on any rising edge where valid && ready.
    // Frame side: frame_valid/frame_ready. Word side: data_valid/data_ready.
    // data_valid never drops without a beat; frame_ready may depend on data_ready.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [FIFO_SIZE*DATA_WIDTH-1:0] frame_q, frame_d;
    logic [DATA_WIDTH-1:0]           word_sel;
    logic                            frame_acc;
    logic                            beat;

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < FIFO_SIZE; k++) begin
            if (idx_q == IDX_W'(k)) begin
                word_sel = frame_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign data_valid  = (state_q == SHIFT);
    assign data_last   = data_valid && (idx_q == LAST_IDX);
    assign data_out    = data_valid ? word_sel : '0;
    assign busy        = data_valid;
    // Accepting on the final beat lets the next frame start without a gap.
    assign frame_ready = !data_valid || (data_last && data_ready);

    assign frame_acc = frame_valid && frame_ready;
    assign beat      = data_valid && data_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        if (frame_acc) begin
            frame_d = frame_in;
            idx_d   = '0;
            state_d = SHIFT;
        end else if (beat) begin
            if (data_last) begin
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Self-checking bench for frame_serializer: scoreboard queues filled on frame
// accept, drained by monitors on each output beat.
module tb_frame_serializer;

    localparam int FS = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [FS*DW-1:0] frame_in = '0;
    logic             frame_valid = 1'b0;
    logic             frame_ready;
    logic [DW-1:0]    data_out;
    logic             data_valid;
    logic             data_ready = 1'b0;
    logic             data_last;
    logic             busy;

    logic [DW-1:0]    frame_in1 = '0;
    logic             frame_valid1 = 1'b0;
    logic             frame_ready1;
    logic [DW-1:0]    data_out1;
    logic             data_valid1;
    logic             data_ready1 = 1'b0;
    logic             data_last1;
    logic             busy1;

    frame_serializer #(.FIFO_SIZE(FS), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_last   (data_last),
        .busy        (busy)
    );

    frame_serializer #(.FIFO_SIZE(1), .DATA_WIDTH(DW)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in1),
        .frame_valid (frame_valid1),
        .frame_ready (frame_ready1),
        .data_out    (data_out1),
        .data_valid  (data_valid1),
        .data_ready  (data_ready1),
        .data_last   (data_last1),
        .busy        (busy1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int            beat_cyc[$];
    logic [DW-1:0] exp1_q[$];
    int            beat1_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Main monitor: compares every beat against the scoreboard and checks stall hold.
    initial begin
        logic          stall_q;
        logic [DW-1:0] stall_data;
        logic          stall_last;
        stall_q    = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    check("stall_valid", 32'(data_valid), 32'd1);
                    check("stall_data", 32'(data_out), 32'(stall_data));
                    check("stall_last", 32'(data_last), 32'(stall_last));
                end
                check("busy_eq_valid", 32'(busy), 32'(data_valid));
                if (data_valid && data_ready) begin
                    if (exp_q.size() == 0) begin
                        check("beat_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
                        check("data_last", 32'(data_last), 32'(exp_last_q.pop_front()));
                        beat_cyc.push_back(cyc + 1);
                    end
                end
                stall_q    = data_valid && !data_ready;
                stall_data = data_out;
                stall_last = data_last;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && data_valid1 && data_ready1) begin
            if (exp1_q.size() == 0) begin
                check("f1_beat_expected", 32'(exp1_q.size()), 32'd1);
            end else begin
                check("f1_data", 32'(data_out1), 32'(exp1_q.pop_front()));
                check("f1_last", 32'(data_last1), 32'd1);
                beat1_cyc.push_back(cyc + 1);
            end
        end
    end

    task automatic send_frame(input logic [FS*DW-1:0] f, input bit hold, output int acc_edge);
        bit done;
        done        = 1'b0;
        acc_edge    = -1;
        frame_in    = f;
        frame_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (frame_ready) begin
                done     = 1'b1;
                acc_edge = cyc + 1;
                for (int k = 0; k < FS; k++) begin
                    exp_q.push_back(f[k*DW +: DW]);
                    exp_last_q.push_back(k == FS - 1);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!hold) frame_valid = 1'b0;
        if (!done) check("frame_accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !data_valid) break;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle_valid"}, 32'(data_valid), 32'd0);
    endtask

    initial begin
        int acc_a;
        int acc_b;
        int nb;
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};

        // Reset state
        #2;
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_last", 32'(data_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_ready", 32'(frame_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single frame, free-flowing
        data_ready = 1'b1;
        beat_cyc.delete();
        send_frame(32'h04030201, 1'b0, acc_a);
        wait_idle("t1");
        check("t1_beats", 32'(beat_cyc.size()), 32'd4);
        check("t1_latency", 32'(beat_cyc[0]), 32'(acc_a + 1));
        check("t1_span", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);

        // Backpressure
        data_ready = 1'b0;
        beat_cyc.delete();
        send_frame(32'h04030201, 1'b0, acc_a);
        nb = 0;
        for (int i = 0; i < 7; i++) begin
            data_ready = pat[i][0];
            @(negedge clk);
            check("bp_frame_ready", 32'(frame_ready), 32'(nb == 3 && pat[i] == 1));
            if (pat[i] == 1) nb++;
            @(posedge clk);
            #1;
        end
        check("bp_done_valid", 32'(data_valid), 32'd0);
        check("bp_beats", 32'(beat_cyc.size()), 32'd4);

        // Back-to-back frames
        data_ready = 1'b1;
        beat_cyc.delete();
        send_frame(32'h04030201, 1'b1, acc_a);
        send_frame(32'h08070605, 1'b0, acc_b);
        check("b2b_accept_edge", 32'(acc_b), 32'(acc_a + 4));
        wait_idle("b2b");
        check("b2b_beats", 32'(beat_cyc.size()), 32'd8);
        check("b2b_span", 32'(beat_cyc[7] - beat_cyc[0]), 32'd7);

        // Ignored load mid-frame
        beat_cyc.delete();
        send_frame(32'h04030201, 1'b0, acc_a);
        data_ready = 1'b0;
        @(posedge clk);
        #1;
        frame_in    = 32'hDEADBEEF;
        frame_valid = 1'b1;
        @(negedge clk);
        check("ign_frame_ready", 32'(frame_ready), 32'd0);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        data_ready  = 1'b1;
        wait_idle("ign");
        check("ign_beats", 32'(beat_cyc.size()), 32'd4);

        // Reset mid-SHIFT
        send_frame(32'h04030201, 1'b0, acc_a);
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(data_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_frame_ready", 32'(frame_ready), 32'd1);
        check("mid_rst_last", 32'(data_last), 32'd0);
        exp_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_valid", 32'(data_valid), 32'd0);
        data_ready = 1'b1;
        beat_cyc.delete();
        send_frame(32'h44332211, 1'b0, acc_a);
        wait_idle("post_rst");
        check("post_rst_beats", 32'(beat_cyc.size()), 32'd4);

        // FIFO_SIZE = 1 streaming
        data_ready1  = 1'b1;
        frame_valid1 = 1'b1;
        beat1_cyc.delete();
        for (int b = 1; b <= 3; b++) begin
            frame_in1 = 8'(b);
            @(negedge clk);
            check("f1_frame_ready", 32'(frame_ready1), 32'd1);
            if (frame_ready1) exp1_q.push_back(8'(b));
            @(posedge clk);
            #1;
        end
        frame_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("f1_beats", 32'(beat1_cyc.size()), 32'd3);
        check("f1_span", 32'(beat1_cyc[2] - beat1_cyc[0]), 32'd2);
        check("f1_drained", 32'(exp1_q.size()), 32'd0);
        check("f1_idle_valid", 32'(data_valid1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1);
    end

endmodule
